// File: rtl/fifo_2w1r_ctrl_if.sv
// Producer/consumer bundle for the two-write/one-read queue controller.
// master = traffic side (producer + consumer), slave = the controller.
interface fifo_2w1r_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic             valid_in0;
  logic             valid_in1;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_out;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             drop_pulse;

  modport master (
    output data_in0, data_in1, valid_in0, valid_in1, ready_out,
    input  in_ready, data_out, valid_out, count, full, empty, drop_pulse
  );

  modport slave (
    input  data_in0, data_in1, valid_in0, valid_in1, ready_out,
    output in_ready, data_out, valid_out, count, full, empty, drop_pulse
  );
endinterface

// File: rtl/fifo_2w1r_ctrl.sv
// Two-lane compacting write / single-lane read circular queue.
// Valid lanes pack lane-0-first; a cycle is accepted whole or dropped whole.
module fifo_2w1r_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_2w1r_ctrl_if.slave      bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             drop_q, drop_d;

  logic [1:0]       n_wr;
  logic             in_ready_c;
  logic             wr_fire;
  logic             rd_fire;
  logic             empty_c;
  logic [WIDTH-1:0] wdat0;

  always_comb begin
    n_wr       = {1'b0, bus.valid_in0} + {1'b0, bus.valid_in1};
    empty_c    = (count_q == '0);
    // Room for a full pair is required, so a single-lane cycle at DEPTH-1 is also refused.
    in_ready_c = (count_q <= CW'(DEPTH - 2));
    wr_fire    = in_ready_c && (n_wr != 2'd0);
    rd_fire    = !empty_c && bus.ready_out;
    wdat0      = bus.valid_in0 ? bus.data_in0 : bus.data_in1;

    wptr_d  = wptr_q + (wr_fire ? PW'(n_wr) : '0);
    rptr_d  = rptr_q + PW'(rd_fire);
    count_d = count_q + (wr_fire ? CW'(n_wr) : '0) - CW'(rd_fire);
    drop_d  = (bus.valid_in0 || bus.valid_in1) && !in_ready_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is deliberately left unreset; empty gates data_out instead.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem_q[wptr_q] <= wdat0;
    if (wr_fire && bus.valid_in0 && bus.valid_in1)
      mem_q[wptr_q + PW'(1)] <= bus.data_in1;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.empty      = empty_c;
  assign bus.full       = (count_q == CW'(DEPTH));
  assign bus.valid_out  = !empty_c;
  assign bus.data_out   = empty_c ? '0 : mem_q[rptr_q];
  assign bus.count      = count_q;
  assign bus.drop_pulse = drop_q;
endmodule

// File: tb/tb_fifo_2w1r_ctrl.sv
// Bench for fifo_2w1r_ctrl: directed vector table, async-reset check,
// then random traffic against a queue-based reference model.
module tb_fifo_2w1r_ctrl;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fifo_2w1r_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_2w1r_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v0, v1, rdy;
    logic [W-1:0]  d0, d1;
    logic [CW-1:0] cnt;
    logic          vo;
    logic [W-1:0]  dout;
    logic          inr, full, emp, drop;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1,
                     input logic rdy, input int cnt, input logic [W-1:0] dout, input logic drop);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.cnt  = CW'(cnt);
    v.vo   = (cnt != 0);
    v.dout = dout;
    v.inr  = (cnt <= D - 2);
    v.full = (cnt == D);
    v.emp  = (cnt == 0);
    v.drop = drop;
    vq.push_back(v);
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] d0, input logic v1,
                       input logic [W-1:0] d1, input logic rdy);
    bus.valid_in0 = v0; bus.data_in0 = d0;
    bus.valid_in1 = v1; bus.data_in1 = d1;
    bus.ready_out = rdy;
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic [W-1:0] dout, input logic drop);
    chk({tag, ".count"},      64'(bus.count),      64'(cnt));
    chk({tag, ".valid_out"},  64'(bus.valid_out),  64'(cnt != 0));
    chk({tag, ".data_out"},   64'(bus.data_out),   64'(dout));
    chk({tag, ".in_ready"},   64'(bus.in_ready),   64'(cnt <= D - 2));
    chk({tag, ".full"},       64'(bus.full),       64'(cnt == D));
    chk({tag, ".empty"},      64'(bus.empty),      64'(cnt == 0));
    chk({tag, ".drop_pulse"}, 64'(bus.drop_pulse), 64'(drop));
  endtask

  initial begin
    logic [W-1:0] model[$];
    logic [W-1:0] d0, d1;
    logic         v0, v1, rdy, inr_m, drop_m;
    vec_t         v;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    drive(0, '0, 0, '0, 0);

    // Directed table: inputs for one edge, expected state just after it.
    add(0, 0,      1, 32'hA1,  0, 1, 32'hA1, 0);  // single lane 1
    add(0, 0,      0, 0,       1, 0, 0,      0);  // pop -> empty
    add(1, 32'h55, 0, 0,       0, 1, 32'h55, 0);  // single lane 0
    add(0, 0,      0, 0,       1, 0, 0,      0);
    add(1, 0,      1, 32'h100, 0, 2, 0,      0);  // pair fill k=0..3
    add(1, 1,      1, 32'h101, 0, 4, 0,      0);
    add(1, 2,      1, 32'h102, 0, 6, 0,      0);
    add(1, 3,      1, 32'h103, 0, 8, 0,      0);
    add(1, 32'hDEAD, 1, 32'hBEEF, 0, 8, 0,   1);  // drop while full
    add(1, 32'hDEAD, 1, 32'hBEEF, 0, 8, 0,   1);  // back-to-back drop
    add(0, 0,      0, 0,       0, 8, 0,      0);
    add(0, 0,      0, 0,       1, 7, 32'h100, 0);
    add(0, 0,      0, 0,       1, 6, 1,      0);
    add(1, 32'h200, 1, 32'h201, 1, 7, 32'h101, 0); // write pair + pop at count 6
    add(0, 0,      0, 0,       1, 6, 2,      0);
    add(0, 0,      0, 0,       1, 5, 32'h102, 0);
    add(0, 0,      0, 0,       1, 4, 3,      0);
    add(0, 0,      0, 0,       1, 3, 32'h103, 0);
    add(0, 0,      0, 0,       1, 2, 32'h200, 0);
    add(0, 0,      0, 0,       1, 1, 32'h201, 0);
    add(0, 0,      0, 0,       1, 0, 0,      0);
    add(0, 0,      0, 0,       1, 0, 0,      0);  // ready while empty

    repeat (3) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk) drive(v.v0, v.d0, v.v1, v.d1, v.rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.count", i),      64'(bus.count),      64'(v.cnt));
      chk($sformatf("vec%0d.valid_out", i),  64'(bus.valid_out),  64'(v.vo));
      chk($sformatf("vec%0d.data_out", i),   64'(bus.data_out),   64'(v.dout));
      chk($sformatf("vec%0d.in_ready", i),   64'(bus.in_ready),   64'(v.inr));
      chk($sformatf("vec%0d.full", i),       64'(bus.full),       64'(v.full));
      chk($sformatf("vec%0d.empty", i),      64'(bus.empty),      64'(v.emp));
      chk($sformatf("vec%0d.drop_pulse", i), 64'(bus.drop_pulse), 64'(v.drop));
    end

    // Async reset mid-cycle: load three entries plus a drop-free state, then clear between edges.
    @(negedge clk) drive(1, 32'h11, 1, 32'h22, 0);
    @(negedge clk) drive(1, 32'h33, 0, 0, 0);
    @(posedge clk); #1 chk_all("prearst", 3, 32'h11, 0);
    @(negedge clk) drive(0, 0, 0, 0, 0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_all("arst", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk_all("post_arst", 0, 0, 0);

    // Random traffic against an ordered-queue model.
    for (int c = 0; c < 400; c++) begin
      v0  = 1'($urandom_range(0, 1));
      v1  = 1'($urandom_range(0, 1));
      d0  = $urandom;
      d1  = $urandom;
      rdy = ($urandom_range(0, 2) == 0);
      @(negedge clk) drive(v0, d0, v1, d1, rdy);
      inr_m  = (model.size() <= D - 2);
      drop_m = (v0 || v1) && !inr_m;
      if (rdy && model.size() > 0) void'(model.pop_front());
      if (inr_m) begin
        if (v0) model.push_back(d0);
        if (v1) model.push_back(d1);
      end
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", c), model.size(), (model.size() > 0) ? model[0] : '0, drop_m);
      chk($sformatf("rnd%0d.bound", c), 64'(bus.count <= CW'(D)), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
